// File: rtl/clock_display_scan.sv
// clock_display_scan: time-multiplexed 4-digit 7-segment driver for an HH:MM clock
//   Parameters:
//     REFRESH_DIV   clk cycles per digit slot (>= 2)
//     BLANK_CYCLES  cycles at slot start with all anodes off (< REFRESH_DIV)
//   Ports:
//     clk       in   system clock, rising edge
//     rst       in   asynchronous reset, active-low
//     enable    in   scan enable; 0 = display dark, scan frozen
//     sec_tick  in   1 Hz one-cycle pulse, toggles the colon
//     hr_high   in   hour tens (BCD)      hr_low  in  hour units (BCD)
//     min_high  in   minute tens (BCD)    min_low in  minute units (BCD)
//     seg_n     out  segments {g,f,e,d,c,b,a}, active-low
//     dp_n      out  decimal point / colon, active-low
//     an_n      out  digit anodes, active-low; [0]=min_low ... [3]=hr_high
//   Build option: HR_ZERO_BLANK_EN suppresses a leading zero in the hour tens digit.
module clock_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sec_tick,
    input  logic [1:0] hr_high,
    input  logic [3:0] hr_low,
    input  logic [2:0] min_high,
    input  logic [3:0] min_low,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n
);
    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          colon_on;
    logic          snap_valid;
    logic [1:0]    snap_hh;
    logic [3:0]    snap_hl;
    logic [2:0]    snap_mh;
    logic [3:0]    snap_ml;
    logic          slot_end;
    logic          blank;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;

    always_comb begin
        slot_end = cnt == CW'(REFRESH_DIV - 1);
        blank    = cnt < CW'(BLANK_CYCLES);
        digit    = idx == 2'd0 ? snap_ml :
                   idx == 2'd1 ? {1'b0, snap_mh} :
                   idx == 2'd2 ? snap_hl : {2'b00, snap_hh};
        case (digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
`ifdef HR_ZERO_BLANK_EN
        if (idx == 2'd3 && snap_hh == 2'd0) seg_dec = 7'h7F;
`else
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            idx        <= '0;
            colon_on   <= 1'b1;
            snap_valid <= 1'b0;
            snap_hh    <= '0;
            snap_hl    <= '0;
            snap_mh    <= '0;
            snap_ml    <= '0;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            an_n       <= 4'hF;
        end else begin
            if (sec_tick) colon_on <= ~colon_on;
            if (enable) begin
                cnt <= slot_end ? '0 : cnt + 1'b1;
                if (slot_end) idx <= idx + 2'd1;
                // All four digits are captured together so a frame never mixes old and new time.
                if (!snap_valid || (idx == 2'd3 && slot_end)) begin
                    snap_valid <= 1'b1;
                    snap_hh    <= hr_high;
                    snap_hl    <= hr_low;
                    snap_mh    <= min_high;
                    snap_ml    <= min_low;
                end
                an_n  <= blank ? 4'hF : ~(4'b0001 << idx);
                seg_n <= blank ? 7'h7F : seg_dec;
                dp_n  <= blank || idx != 2'd2 ? 1'b1 : ~colon_on;
            end else begin
                an_n  <= 4'hF;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end
        end
    end
endmodule
